// File: rtl/moving_average_filter.sv
// rtl/moving_average_filter.sv - boxcar filter: truncated mean of the last 2**LOG2_TAPS samples
module moving_average_filter #(
  parameter int WIDTH     = 8,
  parameter int LOG2_TAPS = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] IN,
  output logic [WIDTH-1:0] Average_out
);

  localparam int TAPS  = 1 << LOG2_TAPS;
  localparam int SUM_W = WIDTH + LOG2_TAPS;

  logic [WIDTH-1:0] taps [TAPS];
  logic [SUM_W-1:0] sum;
  logic [SUM_W-1:0] sum_next;

  // sum always equals the total of the taps, so the subtraction never wraps
  always_comb begin
    sum_next = sum + SUM_W'(IN) - SUM_W'(taps[TAPS-1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        taps[k] <= '0;
      end
      sum         <= '0;
      Average_out <= '0;
    end else begin
      taps[0] <= IN;
      for (int k = 1; k < TAPS; k++) begin
        taps[k] <= taps[k-1];
      end
      sum         <= sum_next;
      Average_out <= sum_next[SUM_W-1:LOG2_TAPS];
    end
  end

endmodule

// File: tb/tb_moving_average_filter.sv
// tb/tb_moving_average_filter.sv - self-checking bench for moving_average_filter
module tb_moving_average_filter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] IN  = 8'h00;
  logic [7:0] Average_out;

  int checks   = 0;
  int failures = 0;

  int hist [4];

  typedef struct {
    logic       r;
    logic [7:0] din;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [$];

  moving_average_filter #(.WIDTH(8), .LOG2_TAPS(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN          (IN),
    .Average_out (Average_out)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [7:0] din, input logic [7:0] exp);
    vec_t v;
    v.r = r;
    v.din = din;
    v.exp = exp;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] model_avg();
    int s;
    s = hist[0] + hist[1] + hist[2] + hist[3];
    return 8'(s / 4);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%02h expected=%02h", name, act, exp);
    end
  endtask

  // one clock edge with the given inputs; the model window follows along
  task automatic apply(input logic r, input logic [7:0] din);
    rst = r;
    IN  = din;
    @(posedge clk);
    #1;
    if (r) begin
      hist = '{0, 0, 0, 0};
    end else begin
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = int'(din);
    end
  endtask

  initial begin
    hist = '{0, 0, 0, 0};

    // reset holds output at zero and ignores IN
    add(1'b1, 8'hAA, 8'h00);
    add(1'b1, 8'hAA, 8'h00);
    add(1'b0, 8'h00, 8'h00);
    // fill ramp
    for (int i = 0; i < 5; i++) add(1'b0, 8'h40, (i < 4) ? 8'((i + 1) * 16) : 8'h40);
    // full scale
    add(1'b1, 8'h00, 8'h00);
    add(1'b0, 8'hFF, 8'h3F);
    add(1'b0, 8'hFF, 8'h7F);
    add(1'b0, 8'hFF, 8'hBF);
    add(1'b0, 8'hFF, 8'hFF);
    add(1'b0, 8'hFF, 8'hFF);
    // truncation
    add(1'b1, 8'h00, 8'h00);
    add(1'b0, 8'h01, 8'h00);
    add(1'b0, 8'h02, 8'h00);
    add(1'b0, 8'h00, 8'h00);
    add(1'b0, 8'h00, 8'h00);
    add(1'b0, 8'h03, 8'h01);
    add(1'b0, 8'h03, 8'h01);
    add(1'b0, 8'h03, 8'h02);
    add(1'b0, 8'h02, 8'h02);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i].r, vecs[i].din);
      check($sformatf("vec%0d", i), Average_out, vecs[i].exp);
    end

    // mid-run reset discards a full window
    for (int i = 0; i < 4; i++) apply(1'b0, 8'hFF);
    check("midrst_full", Average_out, 8'hFF);
    apply(1'b1, 8'hFF);
    check("midrst_rst", Average_out, 8'h00);
    apply(1'b0, 8'h80);
    check("midrst_first", Average_out, 8'h20);
    apply(1'b0, 8'h80);
    check("midrst_second", Average_out, 8'h40);

    // random stream from a zero window, with occasional resets
    apply(1'b1, 8'h00);
    check("rand_rst", Average_out, 8'h00);
    for (int i = 0; i < 100; i++) begin
      logic r;
      logic [7:0] d;
      r = (i > 10) && ($urandom_range(0, 24) == 0);
      d = 8'($urandom_range(0, 255));
      apply(r, d);
      check($sformatf("rand%0d", i), Average_out, model_avg());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
